// File: rtl/adder_pkg.sv
// Shared types and default sizing for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_CHUNK = 8;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for the pipelined adder. The master produces
// operand beats and consumes results; the slave is the adder.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_carry, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_carry, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple slice; also reports the carry into its top
// bit so the last slice can derive signed overflow.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
    // the sum bit is a^b^carry_in, so the carry into the top bit falls out
    cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor pipelined as STAGES ripple slices of CHUNK bits,
// one slice per stage, with a registered carry between stages.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic             in_sub_i,
  input  logic             in_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_carry_o,
  output logic             out_overflow_o
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Handshake: a beat moves on a rising edge when valid and ready are both
  // high; valid never waits on ready, and a held beat keeps its payload.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic              cmsb_q, cmsb_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];

  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_carry;
  logic [WIDTH-1:0]  up_a   [STAGES];
  logic [WIDTH-1:0]  up_b   [STAGES];
  logic [WIDTH-1:0]  up_sum [STAGES];
  logic [CHUNK-1:0]  sl_sum [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic [STAGES-1:0] sl_cmsb;
  logic [WIDTH-1:0]  b_eff;
  logic              unused_bits;

  assign b_eff    = (op_e'(in_sub_i) == OP_SUB) ? ~in_b_i : in_b_i;
  assign up_valid = STAGES'({valid_q, in_valid_i});
  assign up_carry = STAGES'({carry_q, in_carry_i});

  // Operands and partial sum shift right by CHUNK per stage, so every stage
  // consumes the low slice and the finished sum lands fully aligned.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_a[k]   = in_a_i;
      assign up_b[k]   = b_eff;
      assign up_sum[k] = '0;
    end else begin : g_rest
      assign up_a[k]   = a_q[k-1];
      assign up_b[k]   = b_q[k-1];
      assign up_sum[k] = sum_q[k-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (up_a[k][CHUNK-1:0]),
      .b    (up_b[k][CHUNK-1:0]),
      .cin  (up_carry[k]),
      .sum  (sl_sum[k]),
      .cout (sl_cout[k]),
      .cmsb (sl_cmsb[k])
    );
  end

  always_comb begin
    logic rdy;
    rdy   = out_ready_i;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy      = rdy | ~valid_q[k];
      ready[k] = rdy;
    end
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = up_valid[k];
        carry_d[k] = sl_cout[k];
        a_d[k]     = up_a[k] >> CHUNK;
        b_d[k]     = up_b[k] >> CHUNK;
        sum_d[k]   = (up_sum[k] >> CHUNK) | (WIDTH'(sl_sum[k]) << (WIDTH - CHUNK));
      end
    end
    if (ready[STAGES-1]) begin
      cmsb_d = sl_cmsb[STAGES-1];
    end
  end

  // Only the output stage's payload is reset, so outputs read 0 in reset.
  always_ff @(posedge clk_i) begin
    a_q <= a_d;
    b_q <= b_d;
    for (int k = 0; k < STAGES; k++) begin
      if (!rst_ni && (k == STAGES - 1)) begin
        sum_q[k] <= '0;
      end else begin
        sum_q[k] <= sum_d[k];
      end
    end
    if (!rst_ni) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
    end
  end

  assign in_ready_o     = ready[0];
  assign out_valid_o    = valid_q[STAGES-1];
  assign out_sum_o      = sum_q[STAGES-1];
  assign out_carry_o    = carry_q[STAGES-1];
  assign out_overflow_o = carry_q[STAGES-1] ^ cmsb_q;

  assign unused_bits = ^{sl_cmsb, a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, CHUNK=8): directed corner
// cases, random bursts, backpressure and mid-flight reset.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = ADDER_WIDTH;
  localparam int C = ADDER_CHUNK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (bus.in_valid),
    .in_ready_o     (bus.in_ready),
    .in_a_i         (bus.in_a),
    .in_b_i         (bus.in_b),
    .in_sub_i       (bus.in_sub),
    .in_carry_i     (bus.in_carry),
    .out_valid_o    (bus.out_valid),
    .out_ready_i    (bus.out_ready),
    .out_sum_o      (bus.out_sum),
    .out_carry_o    (bus.out_carry),
    .out_overflow_o (bus.out_overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];
  int           stamp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  int           rcv_cnt = 0;
  logic         chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // {overflow, carry, sum} from plain integer arithmetic
  function automatic logic [W+1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   f;
    logic         c_in_msb;
    bb       = sub ? ~b : b;
    f        = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    c_in_msb = a[W-1] ^ bb[W-1] ^ f[W-1];
    return {c_in_msb ^ f[W], f[W], f[W-1:0]};
  endfunction

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic cin, input logic [W+1:0] exp);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_carry = cin;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp);
        stamp_q.push_back(cyc);
        acc_cnt++;
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("send_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic rsend();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    a   = $urandom();
    b   = $urandom();
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
    send(a, b, sub, cin, golden(a, b, sub, cin));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] act;
    act = {bus.out_overflow, bus.out_carry, bus.out_sum};
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(exp_q.size()), 64'd1);
      end else if (bus.out_ready) begin
        chk("result", 64'(act), 64'(exp_q[0]));
        if (chk_lat) chk("latency", 64'(cyc - stamp_q[0]), 64'd4);
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
        rcv_cnt++;
      end else begin
        chk("stall_hold", 64'(act), 64'(exp_q[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b1;

    // reset and empty state
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rel_out_sum", 64'(bus.out_sum), 64'd0);
    @(posedge clk);
    #1;

    // full carry ripple, with latency measured
    chk_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h1_0000_0000);
    bus.in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    // signed overflow, then subtracts with and without borrow
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h2_8000_0000);
    send(32'd5, 32'd7, 1'b1, 1'b1, 34'h0_FFFF_FFFE);
    send(32'd7, 32'd5, 1'b1, 1'b1, 34'h1_0000_0002);
    send(32'h8000_0000, 32'd1, 1'b1, 1'b1, 34'h3_7FFF_FFFF);
    bus.in_valid = 1'b0;
    drain();

    // random back-to-back stream at full throughput
    base = rcv_cnt;
    for (int i = 0; i < 10; i++) rsend();
    bus.in_valid = 1'b0;
    drain();
    chk("stream_count", 64'(rcv_cnt - base), 64'd10);

    // backpressure: fill, stall six cycles, then toggle ready
    base = rcv_cnt;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) rsend();
        bus.in_valid = 1'b0;
      end
      begin
        int acc0;
        acc0 = acc_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_accepted", 64'(acc_cnt - acc0), 64'd4);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 60 && (rcv_cnt - base) < 8; i++) begin
          bus.out_ready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(rcv_cnt - base), 64'd8);

    // reset with three beats in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rsend();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = rcv_cnt;
    send(32'h10, 32'h20, 1'b0, 1'b0, 34'h0_0000_0030);
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_flight_count", 64'(rcv_cnt - base), 64'd1);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
